// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC operand sequencer.
// Holds the FSM encoding, the float32 container type and the qNaN returned on watchdog expiry.
package cordic_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  localparam float32_t FLOAT32_QNAN    = 32'h7FC0_0000;
  localparam int       DEF_FIFO_DEPTH  = 4;
  localparam int       DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/cordic_seq_fifo.sv
// Synchronous show-ahead FIFO: head_dat is the oldest entry whenever empty is low.
// Zero-latency read; caller must not push when full or pop when empty.
module cordic_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cordic_seq.sv
// Queues float angles and feeds them one at a time to an external CORDIC core, holding each result until accepted.
// Optional watchdog under CORDIC_SEQ_TIMEOUT_EN returns qNaN and sets sticky err when the core stalls in BUSY.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        core_start,
  output logic [31:0] core_x_ft,
  input  logic        core_done,
  input  logic [31:0] core_y_ft,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] res_cnt
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cordic_seq: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end

  seq_state_t state;
  float32_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       busy_first;

  assign in_ready   = reset & clk_en & ~fifo_full;
  assign push       = in_valid & in_ready;
  assign pop        = clk_en & ~fifo_empty &
                      ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
  assign core_start = clk_en & (state == ST_ISSUE);

  cordic_seq_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;

  logic [WD_W-1:0] wdog;
  logic            err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      core_x_ft  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      res_cnt    <= '0;
      busy_first <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      wdog       <= '0;
      err_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            core_x_ft <= fifo_head;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          busy_first <= 1'b1;
          state      <= ST_BUSY;
`ifdef CORDIC_SEQ_TIMEOUT_EN
          wdog       <= '0;
`endif
        end
        ST_BUSY: begin
          // core_done may still be high from the previous operation on the first BUSY cycle.
          busy_first <= 1'b0;
          if (!busy_first && core_done) begin
            out_data  <= core_y_ft;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
`ifdef CORDIC_SEQ_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            out_data  <= FLOAT32_QNAN;
            out_valid <= 1'b1;
            err_q     <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            wdog <= wdog + WD_ONE;
          end
`endif
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            res_cnt   <= res_cnt + 16'd1;
            if (!fifo_empty) begin
              core_x_ft <= fifo_head;
              state     <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq: behavioural core model, result scoreboard, vector table and directed corners.
module tb_cordic_seq;
  import cordic_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        core_done = 1'b0;
  logic [31:0] core_y_ft = '0;
  logic        in_ready, core_start, out_valid, err;
  logic [31:0] core_x_ft, out_data;
  logic [15:0] res_cnt;

  cordic_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_start(core_start), .core_x_ft(core_x_ft),
    .core_done(core_done), .core_y_ft(core_y_ft),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err(err), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // The pretend CORDIC core: known answer for 1.0, a fixed scramble otherwise.
  function automatic logic [31:0] core_f(input logic [31:0] x);
    return (x == 32'h3F80_0000) ? 32'h3F0A_5140 : (x ^ 32'h5A5A_C3C3);
  endfunction

  // Core model: answers core_lat cycles after start, done is a level held until the next start.
  int          core_lat   = 5;
  logic        stuck      = 1'b0;
  logic        never_mode = 1'b0;
  int          cnt        = 0;
  logic        done_lvl   = 1'b0;
  logic [31:0] px         = '0;

  always @(negedge clk) begin
    if (!reset) begin
      cnt      = 0;
      done_lvl = 1'b0;
    end else if (core_start && clk_en) begin
      px       = core_x_ft;
      done_lvl = 1'b0;
      cnt      = never_mode ? 0 : core_lat;
      if (stuck) core_y_ft = core_f(px);
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        done_lvl  = 1'b1;
        core_y_ft = core_f(px);
      end
    end
    core_done = done_lvl | stuck;
  end

  // Scoreboard: every accepted push must come back once, in order, as the core's answer (qNaN if it never answers).
  logic [31:0] exp_q[$];
  int          starts = 0, handoffs = 0;
  int          last_push_cyc = 0, last_start_cyc = 0, ov_rise_cyc = 0;
  logic        ov_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      starts   = 0;
      handoffs = 0;
      ov_prev  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(never_mode ? FLOAT32_QNAN : core_f(in_data));
        last_push_cyc = cyc;
      end
      if (!clk_en) check("start_gated_by_clk_en", 32'(core_start), 32'd0);
      if (core_start) begin
        check("single_outstanding", 32'(starts - handoffs), 32'd0);
        starts++;
        last_start_cyc = cyc;
      end
      if (out_valid && !ov_prev) ov_rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready && clk_en) begin
        if (exp_q.size() == 0) check("result_without_push", 32'(exp_q.size()), 32'd1);
        else check("result_order", out_data, exp_q.pop_front());
        handoffs++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic drv_edge();
    @(posedge clk); #1;
  endtask

  task automatic wait_ov(input int budget);
    int k;
    k = 0;
    tick();
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    tick();
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_seq(input int n, input logic [31:0] base, output int stall_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    stall_at = -1;
    drv_edge();
    in_valid = 1'b1;
    while (i < n && guard < 1000) begin
      in_data = base + 32'(i) * 32'h0101_0101;
      tick();
      if (in_ready) i++;
      else if (stall_at < 0) stall_at = i;
      drv_edge();
      guard++;
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(i), 32'(n));
  endtask

  typedef struct {
    logic [31:0] x;
    int          lat;
    logic [31:0] y;
    int          ov_cyc;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    int          st;
    logic [31:0] d;
    int          s;
    logic [15:0] r0;

    // out_valid cycle after push = 2 (to start) + max(lat,2) + 1
    vecs[0] = '{32'h3F80_0000, 5, 32'h3F0A_5140, 8};
    vecs[1] = '{32'h4049_0FDB, 2, 32'h1A13_CC18, 5};
    vecs[2] = '{32'h0000_0000, 1, 32'h5A5A_C3C3, 5};
    vecs[3] = '{32'hBF80_0000, 9, 32'hE5DA_C3C3, 12};

    clk_en = 1'b1;
    #1 reset = 1'b0;
    repeat (3) drv_edge();
    tick();
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_res_cnt",    32'(res_cnt),    32'd0);
    check("rst_out_data",   out_data,        32'd0);
    check("rst_core_x_ft",  core_x_ft,       32'd0);
    drv_edge();
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_lat = vecs[i].lat;
      push_seq(1, vecs[i].x, st);
      wait_ov(100);
      check($sformatf("vec%0d_start_latency", i), 32'(last_start_cyc - last_push_cyc), 32'd2);
      check($sformatf("vec%0d_out_latency", i), 32'(ov_rise_cyc - last_push_cyc), 32'(vecs[i].ov_cyc));
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].y);
      tick();
      tick();
      check($sformatf("vec%0d_res_cnt", i), 32'(res_cnt), 32'(i + 1));
    end

    // Burst: one operand in flight plus DEPTH queued before in_ready drops.
    core_lat = 3;
    r0 = res_cnt;
    push_seq(6, 32'h4000_0000, st);
    check("burst_stall_point", 32'(st), 32'(DEPTH + 1));
    wait_drain(300);
    tick();
    check("burst_res_cnt", 32'(res_cnt), 32'(r0 + 16'd6));

    // Result held with downstream stalled; nothing else issues meanwhile.
    drv_edge();
    out_ready = 1'b0;
    push_seq(3, 32'h5000_0000, st);
    wait_ov(100);
    d = out_data;
    s = starts;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_out_data", out_data, d);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_no_start", 32'(starts), 32'(s));
    end
    drv_edge();
    out_ready = 1'b1;
    wait_drain(300);

    // core_done high before ISSUE must be ignored on the first BUSY cycle.
    stuck = 1'b1;
    tick();
    push_seq(1, 32'h4049_0FDB, st);
    wait_ov(100);
    check("stuck_capture_cycle", 32'(ov_rise_cyc - last_start_cyc), 32'd3);
    check("stuck_out_data", out_data, 32'h1A13_CC18);
    wait_drain(100);
    stuck = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      drv_edge();
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      core_lat  = $urandom_range(1, 8);
    end
    drv_edge();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clk_en    = 1'b1;
    wait_drain(1000);
    tick();
    check("random_res_cnt", 32'(res_cnt), 32'(16'(handoffs)));
    check("random_err", 32'(err), 32'd0);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    never_mode = 1'b1;
    drv_edge();
    out_ready = 1'b0;
    push_seq(1, 32'h1111_2222, st);
    wait_ov(200);
    check("timeout_cycle", 32'(ov_rise_cyc - last_start_cyc), 32'(TMO + 1));
    check("timeout_nan", out_data, FLOAT32_QNAN);
    check("timeout_err", 32'(err), 32'd1);
    never_mode = 1'b0;
    core_lat = 4;
    push_seq(1, 32'h3333_4444, st);
    out_ready = 1'b1;
    wait_drain(300);
    check("timeout_err_sticky", 32'(err), 32'd1);
`endif

    // Reset while BUSY with two operands queued.
    core_lat = 30;
    out_ready = 1'b1;
    push_seq(3, 32'h6000_0000, st);
    check("pre_reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    #1;
    check("busy_rst_core_start", 32'(core_start), 32'd0);
    check("busy_rst_core_x_ft",  core_x_ft,       32'd0);
    check("busy_rst_out_valid",  32'(out_valid),  32'd0);
    check("busy_rst_out_data",   out_data,        32'd0);
    check("busy_rst_err",        32'(err),        32'd0);
    check("busy_rst_res_cnt",    32'(res_cnt),    32'd0);
    check("busy_rst_in_ready",   32'(in_ready),   32'd0);
    repeat (3) drv_edge();
    reset = 1'b1;
    tick();
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (40) tick();
    check("after_rst_no_start", 32'(starts), 32'd0);
    check("after_rst_no_result", 32'(out_valid), 32'd0);
    check("after_rst_res_cnt", 32'(res_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
